// File: rtl/mod_symbol_fifo_pkg.sv
// Shared definitions for the symbol FIFO / constellation mapper slice.
// Holds the MODE encodings, the FSM state type, the default amplitude
// constants and the bits-per-symbol helper used by the top level.
package mod_pkg;

   typedef enum logic [1:0] {
      MODE_BPSK = 2'b00,
      MODE_QPSK = 2'b01,
      MODE_OOK  = 2'b10,
      MODE_RSVD = 2'b11
   } mode_t;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_POP,
      ST_SEND
   } state_t;

   localparam int AMP_FULL_DEF = 32767;
   localparam int AMP_QPSK_DEF = 23170;

   // Reserved encoding behaves as BPSK, so only QPSK consumes two bits.
   function automatic logic [1:0] bits_per_sym(input logic [1:0] mode);
      return (mode == MODE_QPSK) ? 2'd2 : 2'd1;
   endfunction

endpackage

// File: rtl/mod_symbol_fifo_bit_fifo.sv
// Single-bit synchronous FIFO.
// Ports:
//   clk, reset : rising-edge clock, synchronous active-high reset
//   wr_en, din : write request and data bit (dropped when full)
//   rd_en      : pop request (ignored when empty)
//   dout       : oldest stored bit (valid whenever not empty)
//   full/empty : occupancy flags derived from the registered count
//   count      : current occupancy, 0..DEPTH
//   overflow   : sticky, set by any write attempted while full
module bit_fifo #(
   parameter int DEPTH = 16
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     wr_en,
   input  logic                     din,
   input  logic                     rd_en,
   output logic                     dout,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   count,
   output logic                     overflow
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   logic [DEPTH-1:0] mem;
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic             do_wr;
   logic             do_rd;

   assign full  = (count == CW'(DEPTH));
   assign empty = (count == '0);
   assign dout  = mem[rd_ptr];

   // Full is judged on the registered count, so a write while full is
   // dropped even if a pop frees a slot on the same edge.
   assign do_wr = wr_en && !full;
   assign do_rd = rd_en && !empty;

   always_ff @(posedge clk) begin
      if (do_wr) begin
         mem[wr_ptr] <= din;
      end
   end

   // Pointers wrap naturally because DEPTH is a power of two.
   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         count    <= '0;
         overflow <= 1'b0;
      end else begin
         if (do_wr) wr_ptr <= wr_ptr + 1'b1;
         if (do_rd) rd_ptr <= rd_ptr + 1'b1;
         case ({do_wr, do_rd})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
         if (wr_en && full) overflow <= 1'b1;
      end
   end

endmodule

// File: rtl/mod_symbol_fifo.sv
// Bit buffer plus constellation mapper.
// Serial bits are buffered in a bit_fifo; on rEN (accepted only in IDLE)
// K bits are popped (1 for BPSK/OOK/reserved, 2 for QPSK) and mapped to a
// signed I/Q pair that is qualified by a one-cycle send_in strobe.
// Ports:
//   CLK, RESET          : rising-edge clock, synchronous active-high reset
//   wEN, dIn            : serial bit write
//   rEN, MODE           : symbol request and modulation select
//   bFull/bEmpty/bCount : FIFO status
//   busy                : FSM not in IDLE
//   send_in             : data_i/data_q valid strobe
//   data_i, data_q      : two's complement samples, held until next SEND
//   overflow/underflow  : sticky error flags, cleared only by RESET
module mod_symbol_fifo
   import mod_pkg::*;
#(
   parameter int DEPTH    = 16,
   parameter int SAMPLE_W = 16,
   parameter int AMP_FULL = AMP_FULL_DEF,
   parameter int AMP_QPSK = AMP_QPSK_DEF
) (
   input  logic                       CLK,
   input  logic                       RESET,
   input  logic                       wEN,
   input  logic                       dIn,
   input  logic                       rEN,
   input  logic [1:0]                 MODE,
   output logic                       bFull,
   output logic                       bEmpty,
   output logic [$clog2(DEPTH):0]     bCount,
   output logic                       busy,
   output logic                       send_in,
   output logic signed [SAMPLE_W-1:0] data_i,
   output logic signed [SAMPLE_W-1:0] data_q,
   output logic                       overflow,
   output logic                       underflow
);

   localparam int CW = $clog2(DEPTH) + 1;

   localparam logic signed [SAMPLE_W-1:0] A_FULL = SAMPLE_W'(AMP_FULL);
   localparam logic signed [SAMPLE_W-1:0] A_QPSK = SAMPLE_W'(AMP_QPSK);

   state_t      state;
   state_t      state_next;
   mode_t       mode_q;
   logic [1:0]  k_q;
   logic [1:0]  pop_n;
   logic [1:0]  sym_bits;
   logic        fifo_dout;
   logic        pop;
   logic        accept;
   logic        uflow_set;
   logic        last_pop;
   logic        b1;
   logic        b0;
   logic signed [SAMPLE_W-1:0] map_i;
   logic signed [SAMPLE_W-1:0] map_q;

   bit_fifo #(.DEPTH(DEPTH)) u_fifo (
      .clk      (CLK),
      .reset    (RESET),
      .wr_en    (wEN),
      .din      (dIn),
      .rd_en    (pop),
      .dout     (fifo_dout),
      .full     (bFull),
      .empty    (bEmpty),
      .count    (bCount),
      .overflow (overflow)
   );

   assign busy    = (state != ST_IDLE);
   assign send_in = (state == ST_SEND);

   always_ff @(posedge CLK) begin
      if (RESET) state <= ST_IDLE;
      else       state <= state_next;
   end

   always_comb begin
      state_next = state;
      pop        = 1'b0;
      accept     = 1'b0;
      uflow_set  = 1'b0;
      last_pop   = 1'b0;
      case (state)
         ST_IDLE: begin
            if (rEN) begin
               if (bCount >= CW'(bits_per_sym(MODE))) begin
                  accept     = 1'b1;
                  state_next = ST_POP;
               end else begin
                  uflow_set = 1'b1;
               end
            end
         end
         ST_POP: begin
            pop = 1'b1;
            if (pop_n + 2'd1 == k_q) begin
               last_pop   = 1'b1;
               state_next = ST_SEND;
            end
         end
         ST_SEND: state_next = ST_IDLE;
         default: state_next = ST_IDLE;
      endcase
   end

   // On the last pop edge the newest bit is still on the FIFO output, so
   // the mapper reads it directly instead of waiting for the shift.
   always_comb begin
      b0    = fifo_dout;
      b1    = (k_q == 2'd2) ? sym_bits[0] : fifo_dout;
      map_i = '0;
      map_q = '0;
      case (mode_q)
         MODE_QPSK: begin
            map_i = b1 ? A_QPSK : -A_QPSK;
            map_q = b0 ? A_QPSK : -A_QPSK;
         end
         MODE_OOK:  map_i = b1 ? A_FULL : '0;
         default:   map_i = b1 ? A_FULL : -A_FULL;
      endcase
   end

   always_ff @(posedge CLK) begin
      if (RESET) begin
         mode_q    <= MODE_BPSK;
         k_q       <= 2'd1;
         pop_n     <= '0;
         sym_bits  <= '0;
         data_i    <= '0;
         data_q    <= '0;
         underflow <= 1'b0;
      end else begin
         if (uflow_set) underflow <= 1'b1;
         if (accept) begin
            mode_q <= mode_t'(MODE);
            k_q    <= bits_per_sym(MODE);
            pop_n  <= '0;
         end
         if (pop) begin
            pop_n    <= pop_n + 2'd1;
            sym_bits <= {sym_bits[0], fifo_dout};
         end
         if (last_pop) begin
            data_i <= map_i;
            data_q <= map_q;
         end
      end
   end

endmodule

// File: doc/mod_symbol_fifo.md
Name: mod_symbol_fifo

Overview:
Parametrised bit-buffer plus constellation mapper for the digital modulation chain. Serial data bits are written one per cycle into a DEPTH-bit synchronous FIFO. On a read request, 1 or 2 bits are popped according to MODE and mapped to a signed I/Q sample pair (BPSK, QPSK Gray, OOK). A one-cycle send_in strobe qualifies the sample to the downstream modulator/DAC path.

Parameters:
DEPTH, 16, FIFO capacity in bits; power of two, at least 4
SAMPLE_W, 16, signed I/Q sample width
AMP_FULL, 32767, BPSK/OOK amplitude
AMP_QPSK, 23170, QPSK per-axis amplitude (0.707 x full scale)

Ports:
CLK  in  1  clock; all logic on rising edge
RESET  in  1  synchronous, active-high reset
wEN  in  1  write enable; writes dIn when not full
dIn  in  1  serial data bit
rEN  in  1  symbol request; sampled only in IDLE
MODE  in  2  00 BPSK, 01 QPSK, 10 OOK, 11 reserved (treated as BPSK)
bFull  out  1  FIFO holds DEPTH bits
bEmpty  out  1  FIFO holds 0 bits
bCount  out  $clog2(DEPTH)+1  current bit occupancy
busy  out  1  FSM not in IDLE
send_in  out  1  one-cycle strobe: data_i/data_q valid
data_i  out  SAMPLE_W  in-phase sample, two's complement
data_q  out  SAMPLE_W  quadrature sample, two's complement
overflow  out  1  sticky: write attempted while full
underflow  out  1  sticky: rEN in IDLE with bCount < K

Behaviour:
- Reset (RESET=1 at an edge): pointers and count 0; bEmpty=1, bFull=0, bCount=0; state IDLE, busy=0; send_in=0; data_i=data_q=0; overflow=underflow=0. Reset overrides everything, including a symbol in progress; partially popped bits are discarded.
- FIFO: write when wEN && !bFull, judged on the registered count. A write while full is dropped and sets overflow, even if a pop occurs in the same cycle. A simultaneous write and pop leaves bCount unchanged. Pointers wrap modulo DEPTH. Bits pop in write order (oldest first).
- K = bits per symbol: 1 for BPSK/OOK/reserved, 2 for QPSK.
- FSM states: IDLE, POP, SEND.
  - IDLE: if rEN && bCount >= K, latch MODE and K, go to POP.
  - IDLE: if rEN && bCount < K, set underflow and stay in IDLE. No pop; outputs unchanged.
  - POP: pop one bit per cycle into a shift register, MSB first, for K cycles. On the last pop edge, register data_i/data_q and go to SEND.
  - SEND: send_in=1 for exactly this cycle, then go to IDLE. rEN is ignored outside IDLE.
- Latency: rEN accepted at edge N. Pops occur at edges N+1..N+K. send_in is high in the cycle after edge N+K. Back-to-back rEN gives one symbol per K+2 cycles.
- Mode changes on MODE after acceptance have no effect on the current symbol.
- Mapping (b1 = first popped bit):
  - BPSK: bit 1 -> I=+AMP_FULL; bit 0 -> I=-AMP_FULL; Q=0.
  - OOK: bit 1 -> I=+AMP_FULL; bit 0 -> I=0; Q=0.
  - QPSK: I = b1 ? +AMP_QPSK : -AMP_QPSK; Q = b0 ? +AMP_QPSK : -AMP_QPSK.
- data_i/data_q hold their value until the next SEND. Amplitude constants are sign-extended/negated at SAMPLE_W; no saturation logic is required because parameters are within range.
- overflow/underflow clear only on RESET.

Decomposition:
- Shared package mod_pkg: MODE encodings, bits_per_sym(mode) function, default amplitude constants, FSM state enum.
- Sub-module bit_fifo (DEPTH parameter): storage, pointers, count, full/empty, overflow. The top level holds the FSM and mapper.

Test Plan:
1. Reset during POP in QPSK with bCount=2 -> next cycle bCount=0, bEmpty=1, state IDLE, send_in=0, data_i=data_q=0.
2. BPSK: write 0,1,0,1, then 4 rEN requests -> data_i = -32767, +32767, -32767, +32767; data_q=0; each send_in 2 cycles after acceptance; bEmpty=1 at end.
3. QPSK: write 1,0,0,1 -> symbol 1 gives I=+23170, Q=-23170; symbol 2 gives I=-23170, Q=+23170; send_in 3 cycles after each acceptance.
4. Fill with DEPTH=16 writes, then a 17th write -> bFull=1, bCount=16, overflow=1. Read back: the first 16 bits are intact in order.
5. QPSK rEN with bCount=1 -> underflow=1, no send_in, bCount stays 1. Then OOK rEN -> I=+32767 or 0 matching the stored bit.
6. Continuous wEN during QPSK pops at bCount=8 -> count nets +1 then -1 per pop/write overlap as specified; bCount stays consistent and no data is lost.
